bl_dim_ctrl: RTL and testbench

BL_DIM_CTRL -- requirements
Module: bl_dim_ctrl

---
 rtl/bl_dim_ctrl_pkg.sv | 33 +++
 rtl/bl_pwm_gen.sv | 49 ++++
 rtl/bl_dim_ctrl.sv | 113 +++++++++++
 tb/tb_bl_dim_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bl_dim_ctrl_pkg.sv
// Shared types and constants for the backlight dimming controller.
// Levels are unsigned 8.4 fixed point; duties are the 8-bit integer part.
package bl_dim_ctrl_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_CALC  = 2'd1,
    S_APPLY = 2'd2,
    S_LOAD  = 2'd3
  } state_e;

  localparam logic [7:0]  PWM_MAX   = 8'd254;
  localparam logic [7:0]  DUTY_FULL = 8'hFF;
  localparam int unsigned FRAC_W    = 4;
  localparam int unsigned LEVEL_W   = 8 + FRAC_W;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 12'hFF0;

  // Clamp a signed level sum into 0..LEVEL_MAX.
  function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [LEVEL_W+1:0] sum);
    if (sum[LEVEL_W+1]) begin
      return '0;
    end else if (sum > $signed({2'b00, LEVEL_MAX})) begin
      return LEVEL_MAX;
    end else begin
      return sum[LEVEL_W-1:0];
    end
  endfunction

  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bl_pwm_gen.sv
// Prescaled 255-tick PWM generator with registered output.
// boundary_o marks the last count of a period; a period boundary is boundary_o & tick_o.
module bl_pwm_gen
  import bl_dim_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] prescale_i,
  input  logic [7:0]  duty_i,
  output logic        tick_o,
  output logic        boundary_o,
  output logic        pwm_o
);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pwm_q, pwm_d;
  logic        tick;

  // Using >= lets a count left above a freshly lowered prescale wrap immediately.
  assign tick = (presc_q >= prescale_i);

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == PWM_MAX) ? 8'd0 : cnt_q + 8'd1;
    end
    // Full duty is forced explicitly so the output can never dip at a wrap.
    pwm_d = (cnt_q < duty_i) || (duty_i == DUTY_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 16'd0;
      cnt_q   <= 8'd0;
      pwm_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
    end
  end

  assign tick_o     = tick;
  assign boundary_o = (cnt_q == PWM_MAX);
  assign pwm_o      = pwm_q;

endmodule

// File: rtl/bl_dim_ctrl.sv
// Frame-synchronous backlight dimming: IIR-smooths a per-frame block statistic,
// clamps it to a minimum duty and loads it into the PWM only on a period boundary.
module bl_dim_ctrl
  import bl_dim_ctrl_pkg::*;
(
  input  logic        iODCK,
  input  logic        iRST,
  input  logic        iV_Duty,
  input  logic [7:0]  iBlockData,
  input  logic [2:0]  iAlpha,
  input  logic [7:0]  iMinDuty,
  input  logic [15:0] iPrescale,
  output logic [7:0]  oDuty,
  output logic        oPWM,
  output logic        oUpdate
);

  state_e               state_q;
  logic                 vd_q;
  logic [7:0]           target_q;
  logic [LEVEL_W-1:0]   level_q;
  logic signed [12:0]   step_q;
  logic [7:0]           shadow_q;
  logic [7:0]           duty_q;
  logic                 update_q;

  logic                 frame_end;
  logic signed [12:0]   diff;
  logic signed [12:0]   shifted;
  logic signed [12:0]   step_d;
  logic signed [13:0]   sum;
  logic [LEVEL_W-1:0]   level_d;
  logic [7:0]           shadow_d;
  logic                 pwm_tick;
  logic                 pwm_last;
  logic                 period_end;

  assign frame_end = vd_q & ~iV_Duty;

  // Target is promoted to 8.4 so the difference carries the fractional bits.
  assign diff    = $signed({1'b0, target_q, {FRAC_W{1'b0}}}) - $signed({1'b0, level_q});
  assign shifted = diff >>> iAlpha;

  // A shift that rounds to zero would stall the level short of the target.
  always_comb begin
    step_d = shifted;
    if (shifted == 13'sd0 && diff != 13'sd0) begin
      step_d = diff[12] ? -13'sd1 : 13'sd1;
    end
  end

  assign sum      = $signed({2'b00, level_q}) + $signed({step_q[12], step_q});
  assign level_d  = sat_level(sum);
  assign shadow_d = max_u8(level_d[LEVEL_W-1 -: 8], iMinDuty);

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= S_WAIT;
      vd_q     <= 1'b0;
      target_q <= 8'hFF;
      level_q  <= LEVEL_MAX;
      step_q   <= 13'sd0;
      shadow_q <= DUTY_FULL;
      duty_q   <= DUTY_FULL;
      update_q <= 1'b0;
    end else begin
      vd_q     <= iV_Duty;
      update_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (frame_end) begin
            target_q <= iBlockData;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          step_q  <= step_d;
          state_q <= S_APPLY;
        end
        S_APPLY: begin
          level_q  <= level_d;
          shadow_q <= shadow_d;
          state_q  <= S_LOAD;
        end
        S_LOAD: begin
          // Frame ends seen here are dropped; the pending shadow stays put.
          if (period_end) begin
            duty_q   <= shadow_q;
            update_q <= 1'b1;
            state_q  <= S_WAIT;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  bl_pwm_gen u_pwm (
    .clk_i      (iODCK),
    .rst_ni     (iRST),
    .prescale_i (iPrescale),
    .duty_i     (duty_q),
    .tick_o     (pwm_tick),
    .boundary_o (pwm_last),
    .pwm_o      (oPWM)
  );

  assign period_end = pwm_tick & pwm_last;

  assign oDuty   = duty_q;
  assign oUpdate = update_q;

endmodule

// File: tb/tb_bl_dim_ctrl.sv
// Directed bench for bl_dim_ctrl: reset state, IIR convergence, min clamp,
// frame drop while loading, constant-duty PWM and reset abort of a pending load.
module tb_bl_dim_ctrl;
  import bl_dim_ctrl_pkg::*;

  logic        iODCK = 1'b0;
  logic        iRST;
  logic        iV_Duty;
  logic [7:0]  iBlockData;
  logic [2:0]  iAlpha;
  logic [7:0]  iMinDuty;
  logic [15:0] iPrescale;
  logic [7:0]  oDuty;
  logic        oPWM;
  logic        oUpdate;

  int n_checks = 0;
  int n_pass   = 0;

  bit          seen;
  int          highs;
  int          upds;
  int          misses;
  int          nframes;
  logic [7:0]  exp_seq [3];

  bl_dim_ctrl dut (
    .iODCK      (iODCK),
    .iRST       (iRST),
    .iV_Duty    (iV_Duty),
    .iBlockData (iBlockData),
    .iAlpha     (iAlpha),
    .iMinDuty   (iMinDuty),
    .iPrescale  (iPrescale),
    .oDuty      (oDuty),
    .oPWM       (oPWM),
    .oUpdate    (oUpdate)
  );

  always #5 iODCK = ~iODCK;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d/%0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // iV_Duty high for one cycle then low; the frame end is taken on the second edge.
  task automatic frame(input logic [7:0] d);
    iBlockData = d;
    iV_Duty    = 1'b1;
    @(negedge iODCK);
    iV_Duty    = 1'b0;
    @(negedge iODCK);
  endtask

  task automatic wait_update(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge iODCK);
      if (oUpdate) got = 1'b1;
    end
  endtask

  task automatic measure(input int n, output int h_o, output int u_o);
    h_o = 0;
    u_o = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge iODCK);
      if (oPWM) h_o++;
      if (oUpdate) u_o++;
    end
  endtask

  task automatic do_reset();
    iRST = 1'b0;
    repeat (2) @(negedge iODCK);
    iRST = 1'b1;
    @(negedge iODCK);
  endtask

  initial begin
    iRST       = 1'b0;
    iV_Duty    = 1'b0;
    iBlockData = 8'h00;
    iAlpha     = 3'd0;
    iMinDuty   = 8'h00;
    iPrescale  = 16'd0;
    exp_seq[0] = 8'hBF;
    exp_seq[1] = 8'h8F;
    exp_seq[2] = 8'h6B;
    repeat (3) @(negedge iODCK);

    // Reset state
    chk("rst_duty",   32'(oDuty), 32'hFF);
    chk("rst_pwm",    32'(oPWM), 32'h0);
    chk("rst_update", 32'(oUpdate), 32'h0);
    chk("rst_state",  32'(dut.state_q), 32'(S_WAIT));
    chk("rst_level",  32'(dut.level_q), 32'hFF0);
    iRST = 1'b1;
    @(negedge iODCK);

    // Alpha 0 jump to 0x40, 64/255 high
    frame(8'h40);
    wait_update(600, seen);
    chk("t1_update_seen", 32'(seen), 32'h1);
    chk("t1_duty", 32'(oDuty), 32'h40);
    @(negedge iODCK);
    measure(255, highs, upds);
    chk("t1_pwm_high_cnt", 32'(highs), 32'd64);
    chk("t1_no_extra_update", 32'(upds), 32'd0);

    // Alpha 2 decay from full brightness towards 0
    do_reset();
    iAlpha = 3'd2;
    for (int i = 0; i < 3; i++) begin
      frame(8'h00);
      wait_update(600, seen);
      chk("t2_update_seen", 32'(seen), 32'h1);
      chk("t2_decay_duty", 32'(oDuty), 32'(exp_seq[i]));
    end
    misses  = 0;
    nframes = 0;
    while (dut.level_q != 12'h000 && nframes < 80) begin
      frame(8'h00);
      wait_update(600, seen);
      if (!seen) misses++;
      nframes++;
    end
    chk("t2_all_updates", 32'(misses), 32'd0);
    chk("t2_level_zero", 32'(dut.level_q), 32'h000);
    chk("t2_duty_zero", 32'(oDuty), 32'h00);
    frame(8'h00);
    wait_update(600, seen);
    chk("t2_stays_zero", 32'(oDuty), 32'h00);

    // Minimum duty clamp
    iAlpha   = 3'd0;
    iMinDuty = 8'h20;
    for (int i = 0; i < 3; i++) begin
      frame(8'h05);
      wait_update(600, seen);
      chk("t3_update_seen", 32'(seen), 32'h1);
      chk("t3_clamped_duty", 32'(oDuty), 32'h20);
    end

    // Constant PWM at duty 0 and duty 255 over 3 periods
    iMinDuty = 8'h00;
    frame(8'h00);
    wait_update(600, seen);
    chk("t5_duty0", 32'(oDuty), 32'h00);
    @(negedge iODCK);
    measure(765, highs, upds);
    chk("t5_pwm_low_hold", 32'(highs), 32'd0);
    frame(8'hFF);
    wait_update(600, seen);
    chk("t5_duty255", 32'(oDuty), 32'hFF);
    @(negedge iODCK);
    measure(765, highs, upds);
    chk("t5_pwm_high_hold", 32'(highs), 32'd765);

    // Second frame end while loading is dropped
    iPrescale = 16'd100;
    frame(8'h33);
    repeat (5) @(negedge iODCK);
    chk("t4_in_load", 32'(dut.state_q), 32'(S_LOAD));
    frame(8'h77);
    chk("t4_still_load", 32'(dut.state_q), 32'(S_LOAD));
    wait_update(26000, seen);
    chk("t4_update_seen", 32'(seen), 32'h1);
    chk("t4_first_value", 32'(oDuty), 32'h33);
    chk("t4_back_wait", 32'(dut.state_q), 32'(S_WAIT));
    measure(500, highs, upds);
    chk("t4_single_update", 32'(upds), 32'd0);
    chk("t4_duty_held", 32'(oDuty), 32'h33);

    // Reset during a pending load of 0x10
    frame(8'h10);
    repeat (5) @(negedge iODCK);
    chk("t6_in_load", 32'(dut.state_q), 32'(S_LOAD));
    iRST = 1'b0;
    #1;
    chk("t6_async_duty", 32'(oDuty), 32'hFF);
    chk("t6_async_update", 32'(oUpdate), 32'h0);
    chk("t6_async_state", 32'(dut.state_q), 32'(S_WAIT));
    @(negedge iODCK);
    iRST = 1'b1;
    measure(2000, highs, upds);
    chk("t6_no_update", 32'(upds), 32'd0);
    chk("t6_duty_full", 32'(oDuty), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
